// File: rtl/mos6502_pkg.sv
// Shared constants and enumerations for the MOS6502 T-state sequencer and
// interrupt controller.
package mos6502_pkg;

   localparam int T0 = 0;
   localparam int T1 = 1;

   localparam logic [7:0] BRK_OPCODE = 8'h00;

   typedef enum logic [1:0] {
      INT_NONE,
      INT_RESET,
      INT_NMI,
      INT_IRQ
   } int_class_e;

   typedef enum logic [1:0] {
      PH_T,
      PH_SD1,
      PH_SD2
   } seq_phase_e;

   function automatic int irq_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mos6502_sequencer_if.sv
// Connects the sequencer to the decoder, the PSR and the interrupt pins.
// The master modport is the sequencer's side.
interface mos6502_sequencer_if #(
   parameter int T_STATES = 6,
   parameter int N_IRQ    = 1
);
   import mos6502_pkg::*;

   localparam int IRQ_W = irq_w(N_IRQ);

   logic                ready;
   logic                next_t;
   logic                clear_t;
   logic                vector_ack;
   logic                i_flag;
   logic                nmi_n;
   logic [N_IRQ-1:0]    irq_n;
   logic [N_IRQ-1:0]    irq_en;

   logic [T_STATES-1:0] t_state;
   logic                sd1;
   logic                sd2;
   logic                sync;
   logic                inject_brk;
   logic                nreset_req;
   logic                nnmi_req;
   logic                nirq_req;
   logic [IRQ_W-1:0]    irq_src;

   modport master (
      input  ready, next_t, clear_t, vector_ack, i_flag, nmi_n, irq_n, irq_en,
      output t_state, sd1, sd2, sync, inject_brk, nreset_req, nnmi_req,
             nirq_req, irq_src
   );

   modport slave (
      output ready, next_t, clear_t, vector_ack, i_flag, nmi_n, irq_n, irq_en,
      input  t_state, sd1, sd2, sync, inject_brk, nreset_req, nnmi_req,
             nirq_req, irq_src
   );

endinterface

// File: rtl/mos6502_sync.sv
// Multi-flop synchroniser for active-low inputs; presets to 1 (idle) on reset.
// STAGES = 0 degenerates to a wire.
module mos6502_sync #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (STAGES == 0) begin : g_bypass
         logic w_unused_clk_rst;
         assign w_unused_clk_rst = i_clk ^ i_rst;
         assign o_q = i_d;
      end else begin : g_chain
         logic [WIDTH-1:0] r_sr [STAGES];

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               for (int i = 0; i < STAGES; i++) r_sr[i] <= '1;
            end else begin
               r_sr[0] <= i_d;
               for (int i = 1; i < STAGES; i++) r_sr[i] <= r_sr[i-1];
            end
         end

         assign o_q = r_sr[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/mos6502_sequencer.sv
// One-hot T-state sequencer with RMW special states, READY stalls, and
// reset/NMI/IRQ capture that injects BRK on the T0->T1 transition.
module mos6502_sequencer
   import mos6502_pkg::*;
#(
   parameter int T_STATES    = 6,
   parameter int N_IRQ       = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   mos6502_sequencer_if.master  bus
);

   localparam int IRQ_W = irq_w(N_IRQ);

   logic                w_nmi_sync;
   logic [N_IRQ-1:0]    w_irq_sync;
   logic [N_IRQ-1:0]    w_irq_act;
   logic                w_irq_pend;
   logic                w_nmi_edge;
   logic                w_t0_to_t1;
   logic                w_ack;
   logic [IRQ_W-1:0]    w_irq_idx;
   int_class_e          w_cls_sel;

   seq_phase_e          r_phase, w_phase_nxt;
   logic [T_STATES-1:0] r_t, w_t_nxt;

   logic                r_nmi_prev;
   logic                r_nmi_latch;
   logic                r_reset_req;
   logic                r_inject;
   int_class_e          r_cls;
   logic [IRQ_W-1:0]    r_irq_src;

   mos6502_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_nmi_sync (
      .i_clk (clk),
      .i_rst (reset),
      .i_d   (bus.nmi_n),
      .o_q   (w_nmi_sync)
   );

   mos6502_sync #(.STAGES(SYNC_STAGES), .WIDTH(N_IRQ)) u_irq_sync (
      .i_clk (clk),
      .i_rst (reset),
      .i_d   (bus.irq_n),
      .o_q   (w_irq_sync)
   );

   assign w_irq_act  = ~w_irq_sync & bus.irq_en;
   assign w_irq_pend = (|w_irq_act) & ~bus.i_flag;
   assign w_nmi_edge = r_nmi_prev & ~w_nmi_sync;
   assign w_t0_to_t1 = bus.ready && (r_phase == PH_T) && r_t[T0] && !bus.next_t;
   assign w_ack      = bus.ready & bus.vector_ack;

   // Lowest-numbered active source wins; scanning downward leaves the lowest.
   always_comb begin
      w_irq_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (w_irq_act[i]) w_irq_idx = IRQ_W'(i);
      end
   end

   always_comb begin
      w_cls_sel = INT_NONE;
      if (r_reset_req)      w_cls_sel = INT_RESET;
      else if (r_nmi_latch) w_cls_sel = INT_NMI;
      else if (w_irq_pend)  w_cls_sel = INT_IRQ;
   end

   always_comb begin
      w_phase_nxt = r_phase;
      w_t_nxt     = r_t;
      if (bus.ready) begin
         unique case (r_phase)
            PH_T: begin
               if (r_t[T0]) begin
                  w_t_nxt = bus.next_t ? T_STATES'(1) : (T_STATES'(1) << T1);
               end else if (bus.clear_t) begin
                  w_phase_nxt = PH_SD1;
                  w_t_nxt     = '0;
               end else if (bus.next_t || r_t[T_STATES-1]) begin
                  w_t_nxt = T_STATES'(1);
               end else begin
                  w_t_nxt = r_t << 1;
               end
            end
            PH_SD1: w_phase_nxt = PH_SD2;
            PH_SD2: begin
               w_phase_nxt = PH_T;
               w_t_nxt     = T_STATES'(1);
            end
            default: begin
               w_phase_nxt = PH_T;
               w_t_nxt     = T_STATES'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= PH_T;
         r_t     <= T_STATES'(1);
      end else begin
         r_phase <= w_phase_nxt;
         r_t     <= w_t_nxt;
      end
   end

   // The NMI edge detector keeps running through READY stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_nmi_prev  <= 1'b1;
         r_nmi_latch <= 1'b0;
         r_reset_req <= 1'b1;
         r_inject    <= 1'b0;
         r_cls       <= INT_NONE;
         r_irq_src   <= '0;
      end else begin
         r_nmi_prev <= w_nmi_sync;
         if (w_ack && (r_cls == INT_NMI)) r_nmi_latch <= 1'b0;
         else if (w_nmi_edge)             r_nmi_latch <= 1'b1;

         if (bus.ready) begin
            r_inject <= w_t0_to_t1 && (w_cls_sel != INT_NONE);
            if (w_ack) begin
               if (r_cls == INT_RESET) r_reset_req <= 1'b0;
               r_cls <= INT_NONE;
            end
            if (w_t0_to_t1) begin
               r_cls <= w_cls_sel;
               if (w_cls_sel == INT_IRQ) r_irq_src <= w_irq_idx;
            end
         end
      end
   end

   assign bus.t_state    = r_t;
   assign bus.sd1        = (r_phase == PH_SD1);
   assign bus.sd2        = (r_phase == PH_SD2);
   assign bus.sync       = r_t[T1];
   assign bus.inject_brk = r_inject;
   assign bus.nreset_req = ~r_reset_req;
   assign bus.nnmi_req   = ~r_nmi_latch;
   assign bus.nirq_req   = ~w_irq_pend;
   assign bus.irq_src    = r_irq_src;

   a_one_hot: assert property (@(posedge clk) disable iff (reset)
      $onehot({r_t, bus.sd1, bus.sd2}));

   a_inject_t1: assert property (@(posedge clk) disable iff (reset)
      bus.inject_brk |-> r_t[T1]);

endmodule

// File: tb/tb_mos6502_sequencer.sv
// Directed plus randomized checks of the sequencer against a cycle-level
// behavioural model of T-state flow and interrupt servicing.
module tb_mos6502_sequencer;

   localparam int T_STATES    = 6;
   localparam int N_IRQ       = 4;
   localparam int SYNC_STAGES = 2;
   localparam int PH_SD1      = 100;
   localparam int PH_SD2      = 101;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   mos6502_sequencer_if #(.T_STATES(T_STATES), .N_IRQ(N_IRQ)) bus ();

   mos6502_sequencer #(
      .T_STATES    (T_STATES),
      .N_IRQ       (N_IRQ),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model state: ph is the T index, or PH_SD1/PH_SD2.
   int         ph;
   bit         m_rreq, m_nlat, m_inj;
   int         m_cls;   // 0 none, 1 reset, 2 nmi, 3 irq
   int         m_src;
   bit         m_nh [0:7];
   logic [3:0] m_ih [0:7];

   function automatic void m_reset();
      ph = 0; m_rreq = 1; m_nlat = 0; m_inj = 0; m_cls = 0; m_src = 0;
      for (int k = 0; k < 8; k++) begin
         m_nh[k] = 1'b1;
         m_ih[k] = 4'hF;
      end
   endfunction

   function automatic void m_edge();
      bit sync_n, prev_n, edge_n, pend, ack, t01;
      logic [3:0] act;
      int low, sel;
      m_nh[0] = bus.nmi_n;
      m_ih[0] = bus.irq_n;
      sync_n = m_nh[SYNC_STAGES];
      prev_n = m_nh[SYNC_STAGES+1];
      edge_n = prev_n && !sync_n;
      act    = ~m_ih[SYNC_STAGES] & bus.irq_en;
      pend   = (act != 4'h0) && !bus.i_flag;
      low    = 0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (act[i]) begin
            low = i;
            break;
         end
      end
      sel = m_rreq ? 1 : (m_nlat ? 2 : (pend ? 3 : 0));
      ack = bus.ready && bus.vector_ack;
      if (ack && m_cls == 2) m_nlat = 0;
      else if (edge_n)       m_nlat = 1;
      if (bus.ready) begin
         t01   = (ph == 0) && !bus.next_t;
         m_inj = t01 && (sel != 0);
         if (ack) begin
            if (m_cls == 1) m_rreq = 0;
            m_cls = 0;
         end
         if (t01) begin
            m_cls = sel;
            if (sel == 3) m_src = low;
         end
         if (ph == PH_SD1)      ph = PH_SD2;
         else if (ph == PH_SD2) ph = 0;
         else if (ph == 0)      ph = bus.next_t ? 0 : 1;
         else if (bus.clear_t)  ph = PH_SD1;
         else if (bus.next_t)   ph = 0;
         else                   ph = (ph + 1) % T_STATES;
      end
      for (int k = 7; k > 0; k--) begin
         m_nh[k] = m_nh[k-1];
         m_ih[k] = m_ih[k-1];
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] et;
      bit enirq;
      et    = (ph < T_STATES) ? (32'd1 << ph) : 32'd0;
      enirq = !(((~m_ih[SYNC_STAGES] & bus.irq_en) != 4'h0) && !bus.i_flag);
      chk({tag, ".t_state"},    32'(bus.t_state),    et);
      chk({tag, ".sd1"},        32'(bus.sd1),        32'(ph == PH_SD1));
      chk({tag, ".sd2"},        32'(bus.sd2),        32'(ph == PH_SD2));
      chk({tag, ".sync"},       32'(bus.sync),       32'(ph == 1));
      chk({tag, ".inject_brk"}, 32'(bus.inject_brk), 32'(m_inj));
      chk({tag, ".nreset_req"}, 32'(bus.nreset_req), 32'(!m_rreq));
      chk({tag, ".nnmi_req"},   32'(bus.nnmi_req),   32'(!m_nlat));
      chk({tag, ".nirq_req"},   32'(bus.nirq_req),   32'(enirq));
      chk({tag, ".irq_src"},    32'(bus.irq_src),    32'(m_src));
   endtask

   task automatic step(input string tag);
      m_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic run_to_t1(input string tag);
      bit got;
      got = 0;
      bus.clear_t    = 1'b0;
      bus.vector_ack = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (ph == 0) begin
            bus.next_t = 1'b0;
            step(tag);
            got = 1;
            break;
         end
         bus.next_t = (ph < T_STATES);
         step(tag);
      end
      bus.next_t = 1'b0;
      chk({tag, ".bound"}, 32'(got), 32'd1);
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      m_reset();
      check_all("async_rst");
      chk("async_rst.t0",   32'(bus.t_state),    32'd1);
      chk("async_rst.sd1",  32'(bus.sd1),        32'd0);
      chk("async_rst.nres", 32'(bus.nreset_req), 32'd0);
      @(posedge clk);
      #1;
      check_all("rst_hold");
      reset = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ready = 1'b1; bus.next_t = 1'b0; bus.clear_t = 1'b0;
      bus.vector_ack = 1'b0; bus.i_flag = 1'b0; bus.nmi_n = 1'b1;
      bus.irq_n = 4'hF; bus.irq_en = 4'h0;
      #1 reset = 1'b1;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset.t0",   32'(bus.t_state),    32'd1);
      chk("reset.nres", 32'(bus.nreset_req), 32'd0);
      chk("reset.nnmi", 32'(bus.nnmi_req),   32'd1);
      reset = 1'b0;

      // Reset-injected BRK, then walk T2..T5 and acknowledge the vector.
      step("rst_t1");
      chk("rst_t1.inject", 32'(bus.inject_brk), 32'd1);
      chk("rst_t1.t",      32'(bus.t_state),    32'd2);
      repeat (4) step("rst_walk");
      chk("rst_walk.t5", 32'(bus.t_state), 32'd32);
      bus.vector_ack = 1'b1;
      step("rst_ack");
      bus.vector_ack = 1'b0;
      chk("rst_ack.nres", 32'(bus.nreset_req), 32'd1);
      chk("rst_ack.t0",   32'(bus.t_state),    32'd1);

      // next_t at T1, clear_t at T2 -> SD1, SD2, T0, T1.
      step("plain_t1");
      chk("plain_t1.inject", 32'(bus.inject_brk), 32'd0);
      bus.next_t = 1'b1;
      step("next_t1");
      bus.next_t = 1'b0;
      chk("next_t1.t0", 32'(bus.t_state), 32'd1);
      step("sd_t1");
      step("sd_t2");
      bus.clear_t = 1'b1;
      step("sd1");
      bus.clear_t = 1'b0;
      chk("sd1.flag", 32'(bus.sd1),     32'd1);
      chk("sd1.t",    32'(bus.t_state), 32'd0);
      step("sd2");
      chk("sd2.flag", 32'(bus.sd2), 32'd1);
      step("sd_t0");
      step("sd_back_t1");
      chk("sd_back_t1.t", 32'(bus.t_state), 32'd2);

      // NMI edge while stalled, a lost second edge, service and ack.
      bus.ready = 1'b0;
      bus.nmi_n = 1'b0;
      step("nmi_stall");
      step("nmi_stall");
      chk("nmi_stall.early", 32'(bus.nnmi_req), 32'd1);
      step("nmi_stall");
      chk("nmi_stall.req",    32'(bus.nnmi_req), 32'd0);
      chk("nmi_stall.frozen", 32'(bus.t_state),  32'd2);
      bus.ready = 1'b1;
      bus.nmi_n = 1'b1;
      repeat (4) step("nmi_hi");
      bus.nmi_n = 1'b0;
      repeat (4) step("nmi_edge2");
      bus.nmi_n = 1'b1;
      run_to_t1("nmi_inj");
      chk("nmi_inj.inject", 32'(bus.inject_brk), 32'd1);
      step("nmi_t2");
      bus.vector_ack = 1'b1;
      step("nmi_ack");
      bus.vector_ack = 1'b0;
      chk("nmi_ack.req", 32'(bus.nnmi_req), 32'd1);
      repeat (4) step("nmi_lost");
      chk("nmi_lost.req", 32'(bus.nnmi_req), 32'd1);

      // Level IRQ with per-source enables, then masked by i_flag.
      bus.irq_n  = 4'b0011;
      bus.irq_en = 4'b1110;
      repeat (3) step("irq_sync");
      chk("irq_sync.req", 32'(bus.nirq_req), 32'd0);
      run_to_t1("irq_inj");
      chk("irq_inj.inject", 32'(bus.inject_brk), 32'd1);
      chk("irq_inj.src",    32'(bus.irq_src),    32'd2);
      bus.i_flag = 1'b1;
      #1;
      chk("irq_mask.req", 32'(bus.nirq_req), 32'd1);
      run_to_t1("irq_masked");
      chk("irq_masked.inject", 32'(bus.inject_brk), 32'd0);

      // NMI outranks a pending IRQ; the IRQ stays pending afterwards.
      bus.ready  = 1'b0;
      bus.i_flag = 1'b0;
      bus.irq_n  = 4'b0111;
      bus.nmi_n  = 1'b0;
      repeat (4) step("both_stall");
      bus.ready = 1'b1;
      run_to_t1("both_inj");
      chk("both_inj.inject", 32'(bus.inject_brk), 32'd1);
      chk("both_inj.src",    32'(bus.irq_src),    32'd2);
      step("both_t2");
      bus.vector_ack = 1'b1;
      step("both_ack");
      bus.vector_ack = 1'b0;
      chk("both_ack.nmi", 32'(bus.nnmi_req), 32'd1);
      chk("both_ack.irq", 32'(bus.nirq_req), 32'd0);
      run_to_t1("irq_after");
      chk("irq_after.inject", 32'(bus.inject_brk), 32'd1);
      chk("irq_after.src",    32'(bus.irq_src),    32'd3);
      bus.nmi_n = 1'b1;

      // Asynchronous reset from SD1, then a held T0 extension.
      step("pre_sd_t2");
      bus.clear_t = 1'b1;
      step("pre_sd1");
      bus.clear_t = 1'b0;
      chk("pre_sd1.flag", 32'(bus.sd1), 32'd1);
      do_reset();
      bus.next_t = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("t0_ext");
         chk("t0_ext.t", 32'(bus.t_state), 32'd1);
      end
      bus.next_t = 1'b0;
      step("t0_ext_t1");
      chk("t0_ext_t1.t",      32'(bus.t_state),    32'd2);
      chk("t0_ext_t1.inject", 32'(bus.inject_brk), 32'd1);

      // Randomized traffic against the model.
      for (int n = 0; n < 800; n++) begin
         bus.ready      = ($urandom_range(0, 7) != 0);
         bus.next_t     = ($urandom_range(0, 5) == 0);
         bus.clear_t    = ($urandom_range(0, 7) == 0);
         bus.vector_ack = (ph != 0) && ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 15) == 0) bus.i_flag = ~bus.i_flag;
         if ($urandom_range(0, 9) == 0)  bus.nmi_n  = ~bus.nmi_n;
         if ($urandom_range(0, 11) == 0) bus.irq_n  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) bus.irq_en = 4'($urandom_range(0, 15));
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mos6502_sequencer.md
Name: mos6502_sequencer

Overview:
- Parametrised T-state sequencer and interrupt controller for the MOS6502 core.
- Owns the one-hot T-state register, the RMW special states SD1/SD2, READY stalls, and interrupt capture: reset request, NMI edge, and N_IRQ level IRQ sources.
- Drives the active-low request lines, the BRK-injection strobe and the T-state vector consumed by the decoder.
- Takes next_t/clear_t/vector_ack back from the decoder.

Parameters:
- T_STATES, 6, number of one-hot T-state bits (T0..T_STATES-1); legal range 4..8.
- N_IRQ, 1, number of active-low level IRQ sources; legal range 1..8.
- SYNC_STAGES, 2, synchroniser flops on nmi_n and irq_n; 0 means no synchroniser.
- IRQ_W, max(1,$clog2(N_IRQ)), width of irq_src; derived, not overridable.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- ready  in  1  1 = advance; 0 = freeze all state except the synchronisers and the NMI edge latch
- next_t  in  1  decoder: finish instruction (go to T0) or extend T0
- clear_t  in  1  decoder: enter SD1 (RMW write-back)
- vector_ack  in  1  decoder: BRK vector high byte fetched, retire the serviced request
- i_flag  in  1  PSR[2] interrupt disable
- nmi_n  in  1  non-maskable interrupt, falling-edge sensitive
- irq_n  in  N_IRQ  level IRQ lines, active low
- irq_en  in  N_IRQ  per-source enable
- t_state  out  T_STATES  one-hot T-state; all-zero while in SD1/SD2
- sd1  out  1  special state 1
- sd2  out  1  special state 2
- sync  out  1  opcode-fetch cycle (t_state[1])
- inject_brk  out  1  force IR := 8'h00 on this T1
- nreset_req  out  1  active-low pending reset
- nnmi_req  out  1  active-low pending NMI
- nirq_req  out  1  active-low pending IRQ
- irq_src  out  IRQ_W  index of the lowest-numbered active enabled IRQ, latched at injection

Behaviour:
- Reset (asynchronous, active-high) forces:
  - t_state = T0 one-hot; sd1 = sd2 = 0.
  - nreset_req = 0, nnmi_req = 1, nirq_req = 1; inject_brk = 0; irq_src = 0.
  - NMI edge latch cleared; synchronisers preset to 1.
- The first T0->T1 after reset therefore injects BRK with the reset vector.
- State transitions occur only when ready = 1. Priority: clear_t > next_t > default advance.
  - Tk (k >= 1): clear_t -> SD1; next_t -> T0; otherwise T(k+1).
  - T(T_STATES-1) with no flag -> T0 (wrap).
  - T0: next_t -> T0 (extension cycle for taken/page-crossing branch); otherwise T1.
  - clear_t is ignored in T0.
  - SD1 -> SD2 unconditionally. SD2 -> T0 unconditionally; next_t/clear_t are ignored in SD1/SD2.
- NMI:
  - The synchronised nmi_n falling edge sets the edge latch, including while ready = 0.
  - nnmi_req = ~latch.
  - Edges occurring while the latch is set are lost (6502 behaviour).
- IRQ: pending_irq = |(~irq_n_sync & irq_en) & ~i_flag, evaluated combinationally; nirq_req = ~pending_irq.
- Interrupt injection:
  - Sampled on the T0->T1 transition. Priority: reset > NMI > IRQ.
  - If any request is pending, inject_brk = 1 for the whole of that T1 and the serviced class is latched.
  - irq_src captures the lowest set index of the enabled active sources at that transition.
  - inject_brk is never asserted outside T1.
- Request retirement:
  - vector_ack with ready = 1 clears the latched class: the reset request or the NMI edge latch.
  - IRQ is level-only; it is not cleared, because the BRK sequence sets i_flag.
  - nreset_req returns to 1 only on that ack.
- An NMI arriving during a reset-injected sequence stays pending and is serviced at the next T0->T1.
- reset asserted mid-instruction or mid-SD aborts immediately to the reset values.
- Exactly one bit of {t_state, sd1, sd2} is set at all times; an assertion checks this.
- No combinational path from next_t/clear_t to any output.

Decomposition:
- Package mos6502_pkg:
  - T-state index constants (T0, T1).
  - Interrupt-class enum {INT_NONE, INT_RESET, INT_NMI, INT_IRQ}.
  - BRK opcode constant 8'h00.
- One sub-module, mos6502_sync: SYNC_STAGES-deep, width-parametrised synchroniser with preset-to-1, instantiated for nmi_n and irq_n.
- Priority encoder and state register stay inline.

Test Plan:
- Release reset, ready = 1, no flags -> T0, T1 (inject_brk = 1, nreset_req = 0), T2..T5. vector_ack at T5 -> nreset_req = 1 the next cycle.
- At T1, next_t = 1 -> T0 next cycle. At T2, clear_t = 1 -> SD1, SD2, T0, T1; t_state = 0 during SD.
- nmi_n falls while ready = 0 -> nnmi_req = 0 after SYNC_STAGES+1 cycles. A second edge before ack is lost; inject at next T0->T1; vector_ack -> nnmi_req = 1.
- N_IRQ = 4, irq_n = 4'b0011, irq_en = 4'b1110, i_flag = 0 -> irq_src = 2, inject_brk at T1. Set i_flag = 1 -> nirq_req = 1, no injection.
- NMI and IRQ both pending at T0->T1 -> NMI serviced (irq_src unchanged); IRQ remains pending afterwards.
- Assert reset during SD1 -> t_state = T0 and nreset_req = 0 asynchronously; T0 held with next_t = 1 for 3 cycles -> stays T0, then T1.
